regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the single write port of the 32 x 64-bit register file between two writeback requesters: port 0 is ALU writeback and port 1 is load writeback. Each cycle it picks one requester by round-robin. It then drives the register file's write-address decoder (enable plus 5-bit select) and write data through one registered stage. Writes to X31 (the zero register) are granted and then discarded. A saturating counter records how many cycles both ports requested at once, for performance debug.

## Interface
Parameters:
- WIDTH, 64, write data width
- ZERO_REG, 31, register index whose writes are suppressed

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- req0  input  1  port 0 requests a write
- addr0  input  5  port 0 destination register
- data0  input  WIDTH  port 0 write data
- gnt0  output  1  port 0 write accepted this cycle (combinational)
- req1  input  1  port 1 requests a write
- addr1  input  5  port 1 destination register
- data1  input  WIDTH  port 1 write data
- gnt1  output  1  port 1 write accepted this cycle (combinational)
- wr_en  output  1  to decoder ena; registered
- wr_sel  output  5  to decoder sel; registered
- wr_data  output  WIDTH  to register-file data inputs; registered
- prio  output  1  requester holding priority next conflict (0 or 1)
- conflict_count  output  16  saturating count of cycles with req0 & req1

## Operation
- Handshake:
  - A transfer occurs on port k in a cycle where reqk & gntk.
  - A requester holds reqk, addrk and datak stable until it sees gntk.
  - It may drop reqk the cycle after the grant.
- Grant rules, with reset low:
  - Only req0: gnt0 = 1.
  - Only req1: gnt1 = 1.
  - Neither: no grant.
  - Both: gnt[prio] = 1 and the other grant is 0.
  - gnt0 and gnt1 are never both 1.
- Priority pointer prio:
  - After any transfer on port k, prio becomes !k at the next edge.
  - With no transfer, prio holds.
  - Consequence: under continuous contention, grants strictly alternate 0,1,0,1.
- Write stage (registered), on every edge:
  - wr_sel and wr_data load the granted port's addr and data.
  - wr_en loads (transfer occurred) & (granted addr != ZERO_REG).
  - With no transfer, wr_en loads 0. wr_sel and wr_data hold their previous values.
- Zero register:
  - A request to addr 31 is granted normally and advances prio.
  - It never produces wr_en = 1.
- conflict_count:
  - Increments by 1 on each edge where req0 & req1 are both high.
  - Saturates at 16'hFFFF; it does not wrap.
- Reset (synchronous):
  - On an edge with reset = 1: wr_en = 0, wr_sel = 0, wr_data = 0, prio = 0, conflict_count = 0.
  - While reset = 1, gnt0 = gnt1 = 0 regardless of requests, so no transfer is lost or half-done.
  - A request pending when reset asserts must be re-presented after reset.

## Timing
- gnt0/gnt1 are a combinational function of req0, req1, prio and reset in the same cycle. There is no register path from addr/data to gnt.
- Latency:
  - A transfer in cycle N appears on wr_en/wr_sel/wr_data during cycle N+1.
  - The register file captures it at the rising edge ending cycle N+1.
  - Readers needing the value in cycle N+1 must forward from wr_sel/wr_data.
- Throughput: one write per cycle sustained; back-to-back transfers from either port or alternating ports are allowed.
- wr_en is a single-cycle pulse per transfer; it is high for consecutive cycles only when transfers are consecutive.
- prio and conflict_count update at the same edge as the write stage.

## Test plan
- Reset: hold reset 2 cycles with req0 = req1 = 1.
  - Required: gnt0 = gnt1 = 0, wr_en = 0, wr_sel = 0, wr_data = 0, prio = 0, conflict_count = 0.
- Single port: req0 = 1, addr0 = 5, data0 = 64'hDEAD_BEEF for one cycle.
  - Required: gnt0 = 1 that cycle.
  - Next cycle: wr_en = 1, wr_sel = 5, wr_data = 64'hDEAD_BEEF.
  - Following cycle: wr_en = 0.
- Contention: req0 = req1 = 1 for 4 cycles from reset (addr0 = 1, addr1 = 2).
  - Required grants: 0,1,0,1.
  - wr_sel one cycle later: 1,2,1,2.
  - conflict_count = 4.
- Zero register: req1 = 1, addr1 = 31.
  - Required: gnt1 = 1, wr_en stays 0 the next cycle, prio becomes 0.
- Saturation: hold req0 = req1 = 1 for 65540 cycles.
  - Required: conflict_count = 16'hFFFF and stays there; grants still alternate.
- Reset mid-stream: assert reset in the cycle after a transfer to addr 7.
  - Required: wr_en = 0 and wr_sel = 0 after that edge, so register 7 sees no write pulse.
  - Required: prio = 0 after that edge.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (port 0)
// and load (port 1) writeback, with one registered write stage and a contention counter.
module regfile_write_arbiter #(
  parameter int          WIDTH    = 64,
  parameter logic [4:0]  ZERO_REG = 5'd31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [4:0]       addr0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [4:0]       addr1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  output logic             wr_en,
  output logic [4:0]       wr_sel,
  output logic [WIDTH-1:0] wr_data,
  output logic             prio,
  output logic [15:0]      conflict_count
);

  // Handshake: a transfer on port k happens in any cycle with reqk & gntk.
  // The requester keeps reqk/addrk/datak stable until it sees gntk and may drop
  // reqk the cycle after. Grants are never issued while reset is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        gnt0 = ~prio;
        gnt1 = prio;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en          <= 1'b0;
      wr_sel         <= 5'd0;
      wr_data        <= '0;
      prio           <= 1'b0;
      conflict_count <= 16'd0;
    end else begin
      if (gnt0) begin
        wr_sel  <= addr0;
        wr_data <= data0;
        wr_en   <= (addr0 != ZERO_REG);
        prio    <= 1'b1;
      end else if (gnt1) begin
        wr_sel  <= addr1;
        wr_data <= data1;
        wr_en   <= (addr1 != ZERO_REG);
        prio    <= 1'b0;
      end else begin
        wr_en <= 1'b0;
      end
      // Performance counter sticks at all-ones instead of wrapping.
      if (req0 && req1 && (conflict_count != 16'hFFFF))
        conflict_count <= conflict_count + 16'd1;
    end
  end

endmodule
